// File: rtl/fft_result_packer.sv
// rtl/fft_result_packer.sv - keeps leading FFT points per range bin and packs point pairs into a 32-bit FIFO
//
// Purpose:
//   Takes the 16-bit FFT result stream (NFFT points per range bin, RANGEBIN_NUM bins per pulse).
//   Keeps the first KEEP_POINTS points of each bin and drops the mirrored half.
//   Packs kept point pairs as {odd point, even point} into an internal FIFO that the host drains.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   start          one-cycle pulse that arms capture of one pulse (RANGEBIN_NUM bins); honoured in IDLE only
//   data_in        FFT result sample
//   data_in_valid  data_in valid this cycle
//   rd_en          downstream read request
//   data_out       packed word {second point, first point}, registered
//   data_out_valid data_out valid, one cycle after an accepted read
//   empty / full   FIFO occupancy flags
//   overflow       sticky flag: a word was dropped because the FIFO was full
//   frame_done     one-cycle pulse after the last sample of the last bin
//   bin_index      range bin currently being collected
//
// Optional feature, macro FFT_RESULT_PACKER_BIN_HEADER_EN:
//   When defined, a header word {16'hA5A5, 8'h00, bin_index} is written at the start of every bin.
//   When undefined, no header logic is built.

module fft_result_packer #(
  parameter int NFFT         = 64,
  parameter int KEEP_POINTS  = 32,
  parameter int RANGEBIN_NUM = 4,
  parameter int ADDR_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic        data_in_valid,
  input  logic        rd_en,
  output logic [31:0] data_out,
  output logic        data_out_valid,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        frame_done,
  output logic [7:0]  bin_index
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = (NFFT > 1) ? $clog2(NFFT) : 1;

  localparam logic [PW-1:0]   KEEP_LAST = PW'(KEEP_POINTS - 1);
  localparam logic [PW-1:0]   NFFT_LAST = PW'(NFFT - 1);
  localparam logic [7:0]      BIN_LAST  = 8'(RANGEBIN_NUM - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam bit              KEEP_ALL  = (KEEP_POINTS == NFFT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DISCARD = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [PW-1:0] point_cnt;
  logic          pair;       // set when the low half holds an even point awaiting its partner
  logic [15:0]   low_half;

  logic start_acc;
  logic bin_end;
  logic sample_acc;

  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ok;
  logic        rd_acc;

  logic [31:0]     mem [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and per-cycle strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    bin_end    = 1'b0;
    sample_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (data_in_valid) begin
          sample_acc = 1'b1;
          if (point_cnt == KEEP_LAST) begin
            // With nothing to discard the bin ends on the last kept point.
            if (KEEP_ALL) bin_end = 1'b1;
            else          state_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (data_in_valid) begin
          sample_acc = 1'b1;
          if (point_cnt == NFFT_LAST) bin_end = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (bin_end) begin
      state_next = (bin_index == BIN_LAST) ? DONE : COLLECT;
    end
  end

  assign frame_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      point_cnt <= '0;
      bin_index <= 8'd0;
      pair      <= 1'b0;
      low_half  <= 16'd0;
    end else begin
      state <= state_next;
      if (start_acc) begin
        point_cnt <= '0;
        bin_index <= 8'd0;
        pair      <= 1'b0;
      end else if (sample_acc) begin
        if (state == COLLECT) begin
          pair <= ~pair;
          if (!pair) low_half <= data_in;
        end
        if (bin_end) begin
          point_cnt <= '0;
          pair      <= 1'b0;
          if (bin_index != BIN_LAST) bin_index <= bin_index + 8'd1;
        end else begin
          point_cnt <= point_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO write source: packed data pairs, optionally preceded by a bin header
  // ---------------------------------------------------------------------------
  logic data_wr;
  assign data_wr = (state == COLLECT) && data_in_valid && pair;

`ifdef FFT_RESULT_PACKER_BIN_HEADER_EN
  // Set on every entry to COLLECT; the header goes out in the first COLLECT
  // cycle, where the pair flag is clear so it never collides with a data word.
  logic hdr_pend;
  logic hdr_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_pend <= 1'b0;
    end else begin
      hdr_pend <= (state_next == COLLECT) && (state != COLLECT || bin_end);
    end
  end

  assign hdr_wr  = (state == COLLECT) && hdr_pend;
  assign wr_en   = hdr_wr || data_wr;
  assign wr_data = hdr_wr ? {16'hA5A5, 8'h00, bin_index} : {data_in, low_half};
`else
  assign wr_en   = data_wr;
  assign wr_data = {data_in, low_half};
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign rd_acc = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO is still taken.
  assign wr_ok  = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow       <= 1'b0;
      data_out       <= 32'd0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= rd_acc;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_acc)           overflow <= 1'b0;
      else if (wr_en && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_result_packer.sv
// tb/tb_fft_result_packer.sv - directed self-checking bench for fft_result_packer

module tb_fft_result_packer;

`ifdef FFT_RESULT_PACKER_BIN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NW = 4 * (16 + HDR);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic        data_in_valid;
  logic        rd_en;
  logic        rd_en_s;

  logic [31:0] data_out, s_data_out;
  logic        data_out_valid, s_data_out_valid;
  logic        empty, s_empty, full, s_full, overflow, s_overflow;
  logic        frame_done, s_frame_done;
  logic [7:0]  bin_index, s_bin_index;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt;
  int max_cnt;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fft_result_packer dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_in_valid(data_in_valid),
    .rd_en(rd_en), .data_out(data_out), .data_out_valid(data_out_valid), .empty(empty),
    .full(full), .overflow(overflow), .frame_done(frame_done), .bin_index(bin_index)
  );

  fft_result_packer #(.ADDR_W(4)) dut_s (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_in_valid(data_in_valid),
    .rd_en(rd_en_s), .data_out(s_data_out), .data_out_valid(s_data_out_valid), .empty(s_empty),
    .full(s_full), .overflow(s_overflow), .frame_done(s_frame_done), .bin_index(s_bin_index)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then observe outputs away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
    if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
    if (data_out_valid) got_q.push_back(data_out);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int idx);
    data_in       = 16'((idx / 64) * 256 + (idx % 64));
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_nwords"}, 32'(got_q.size()), 32'(NW));
    for (int i = 0; i < NW && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
  endtask

  task automatic drain_and_check(input string tag);
    got_q.delete();
    rd_en = 1'b1;
    for (int i = 0; i < NW + 2; i++) begin
      tick();
      chk({tag, "_valid"}, 32'(data_out_valid), 32'(i < NW));
    end
    rd_en = 1'b0;
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    tick();
    chk({tag, "_valid_idle"}, 32'(data_out_valid), 32'd0);
    chk({tag, "_hold"}, data_out, exp_q[NW-1]);
    cmp_words(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = 16'd0; data_in_valid = 1'b0; rd_en = 1'b0; rd_en_s = 1'b0;
    fd_cnt = 0; max_cnt = 0;

    for (int b = 0; b < 4; b++) begin
      if (HDR != 0) exp_q.push_back({16'hA5A5, 8'h00, 8'(b)});
      for (int k = 0; k < 16; k++) exp_q.push_back({16'(b * 256 + 2 * k + 1), 16'(b * 256 + 2 * k)});
    end

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_bin_index", 32'(bin_index), 32'd0);

    // Samples while IDLE are ignored
    for (int i = 0; i < 4; i++) send(i);
    chk("idle_ignore_empty", 32'(empty), 32'd1);

    // Basic frame; the small FIFO instance sees the same frame with no reads
    pulse_start();
    fd_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      send(i);
      if (i == 31) begin
        chk("ovf_full_after_bin0", 32'(s_full), 32'd1);
        chk("ovf_flag_after_bin0", 32'(s_overflow), 32'(HDR));
      end
      if (i == 63) chk("bin_index_1", 32'(bin_index), 32'd1);
      if (i == 255) chk("frame_done_pulse", 32'(frame_done), 32'd1);
    end
    tick();
    chk("frame_done_once", 32'(fd_cnt), 32'd1);
    chk("frame_done_low", 32'(frame_done), 32'd0);
    chk("fifo_count", 32'(dut.count), 32'(NW));
    chk("basic_full", 32'(full), 32'd0);
    chk("ovf_full", 32'(s_full), 32'd1);
    chk("ovf_sticky", 32'(s_overflow), 32'd1);

    // Read handshake: rd_en held for NW+2 cycles
    drain_and_check("basic");

    // Valid gaps: data_in_valid toggles every cycle
    pulse_start();
    chk("ovf_cleared_by_start", 32'(s_overflow), 32'd0);
    fd_cnt = 0;
    for (int c = 0; c < 512; c++) begin
      if (c % 2 == 0) send(c / 2);
      else tick();
    end
    tick();
    chk("gap_frame_done_once", 32'(fd_cnt), 32'd1);
    drain_and_check("gap");

    // Concurrent read and write during capture
    got_q.delete();
    max_cnt = 0;
    rd_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 256; i++) send(i);
    for (int i = 0; i < 4; i++) tick();
    rd_en = 1'b0;
    chk("concurrent_max_count", 32'(max_cnt <= 1), 32'd1);
    chk("concurrent_overflow", 32'(overflow), 32'd0);
    cmp_words("concurrent");

    // Mid-operation reset at sample 100
    pulse_start();
    for (int i = 0; i < 100; i++) send(i);
    chk("pre_rst_not_empty", 32'(empty), 32'd0);
    rst = 1'b1;
    data_in = 16'h1234;
    data_in_valid = 1'b1;
    tick();
    rst = 1'b0;
    data_in_valid = 1'b0;
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_bin_index", 32'(bin_index), 32'd0);
    chk("midrst_state_idle", 32'(dut.state), 32'd0);
    for (int i = 100; i < 120; i++) send(i);
    chk("post_rst_ignored", 32'(empty), 32'd1);
    chk("post_rst_bin_index", 32'(bin_index), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
